// File: rtl/gf_inverter_if.sv
// gf_inverter_if: operand/result valid-ready bus for the GF(2^8) inverter.
interface gf_inverter_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:1] ai;
  logic [8:1] gi;
  logic       out_valid;
  logic       out_ready;
  logic [8:1] ro;
  logic       zero;
  logic       chk_err;
  modport master (output in_valid, ai, gi, out_ready, input in_ready, out_valid, ro, zero, chk_err);
  modport slave  (input in_valid, ai, gi, out_ready, output in_ready, out_valid, ro, zero, chk_err);
endinterface

// File: rtl/gf_inverter.sv
// gf_inverter: sequential GF(2^8) inverse a^254 via square-and-multiply on a bit-serial MSB-first multiplier.
// Optional self-check of A*R == 1 enabled by macro GF_INV_CHECK_EN.
module gf_inverter #(
  parameter int MUL_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  gf_inverter_if.slave   io
);
  localparam int C = 8 / MUL_BITS;
  typedef enum logic [2:0] {
    IDLE, SQR, MUL, DONE
`ifdef GF_INV_CHECK_EN
    , CHK
`endif
  } state_t;
`ifdef GF_INV_CHECK_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t     state_q, state_d;
  logic [8:1] a_q, g_q, r_q, p_q, p_d, x, m;
  logic [2:0] cnt_q, k_q;
  logic       last, busy, done;
`ifdef GF_INV_CHECK_EN
  logic       chk_q;
`endif
  assign last = cnt_q == 3'(C - 1);
  assign busy = !(state_q == IDLE || state_q == DONE);
  assign done = state_q == DONE;
  // Horner evaluation: each step doubles P mod g and adds X for the next multiplier bit of R
  always_comb begin
    x = (state_q == SQR) ? r_q : a_q;
    m = r_q << (cnt_q * MUL_BITS);
    p_d = p_q;
    for (int j = 0; j < MUL_BITS; j++) begin
      p_d = {p_d[7:1], 1'b0} ^ (p_d[8] ? g_q : 8'h00) ^ (m[8] ? x : 8'h00);
      m = {m[7:1], 1'b0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      g_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
`ifdef GF_INV_CHECK_EN
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && io.in_valid) begin
        a_q   <= io.ai;
        g_q   <= io.gi;
        r_q   <= io.ai;
        p_q   <= '0;
        cnt_q <= '0;
        k_q   <= '0;
`ifdef GF_INV_CHECK_EN
        chk_q <= 1'b0;
`endif
      end else if (busy) begin
        cnt_q <= last ? 3'd0 : cnt_q + 3'd1;
        p_q   <= last ? 8'h00 : p_d;
        if (last && (state_q == SQR || state_q == MUL)) r_q <= p_d;
        if (last && state_q == MUL) k_q <= k_q + 3'd1;
`ifdef GF_INV_CHECK_EN
        if (last && state_q == CHK) chk_q <= (p_d != 8'h01) && (a_q != 8'h00);
`endif
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = io.in_valid ? SQR : IDLE;
      SQR:     state_d = !last ? SQR : (k_q == 3'd6) ? FIN : MUL;
      MUL:     state_d = last ? SQR : MUL;
`ifdef GF_INV_CHECK_EN
      CHK:     state_d = last ? DONE : CHK;
`endif
      DONE:    state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    io.in_ready  = state_q == IDLE;
    io.out_valid = done;
    io.ro        = done ? r_q : 8'h00;
    io.zero      = done && (a_q == 8'h00);
`ifdef GF_INV_CHECK_EN
    io.chk_err   = done && chk_q;
`else
    io.chk_err   = 1'b0;
`endif
  end
endmodule

// File: tb/tb_gf_inverter.sv
// tb_gf_inverter: directed and exhaustive checks of gf_inverter at MUL_BITS=1 and MUL_BITS=8.
module tb_gf_inverter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gf_inverter_if b1 ();
  gf_inverter_if b8 ();
  gf_inverter #(.MUL_BITS(1)) u1 (.clk(clk), .rst(rst), .io(b1));
  gf_inverter #(.MUL_BITS(8)) u8 (.clk(clk), .rst(rst), .io(b8));
`ifdef GF_INV_CHECK_EN
  localparam int  NM = 14;
  localparam logic CE = 1'b1;
`else
  localparam int  NM = 13;
  localparam logic CE = 1'b0;
`endif
  int errs = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ g) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction
  task automatic drive(input bit s, input logic v, input logic [7:0] a, input logic [7:0] g);
    if (s) begin b8.in_valid = v; b8.ai = a; b8.gi = g; end
    else   begin b1.in_valid = v; b1.ai = a; b1.gi = g; end
  endtask
  task automatic set_ready(input bit s, input logic v);
    if (s) b8.out_ready = v; else b1.out_ready = v;
  endtask
  task automatic xact(input bit s, input logic [7:0] a, input logic [7:0] g, input bit ack,
                      output logic [7:0] r, output logic z, output logic c, output int lat);
    drive(s, 1'b1, a, g);
    @(posedge clk); #1;
    drive(s, 1'b0, 8'h00, 8'hFF);
    lat = 0;
    while (!(s ? b8.out_valid : b1.out_valid) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    r = s ? b8.ro : b1.ro;
    z = s ? b8.zero : b1.zero;
    c = s ? b8.chk_err : b1.chk_err;
    if (ack) begin
      set_ready(s, 1'b1);
      @(posedge clk); #1;
      set_ready(s, 1'b0);
    end
  endtask
  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] g,
                          input logic [7:0] er, input logic ez, input logic ec);
    logic [7:0] r;
    logic z, c;
    int lat;
    xact(1'b0, a, g, 1'b1, r, z, c, lat);
    check({tag, "_ro"}, r, er);
    check({tag, "_zero"}, z, ez);
    check({tag, "_chk"}, c, ec);
    check({tag, "_lat"}, lat, NM * 8);
    check({tag, "_rdy"}, b1.in_ready, 1'b1);
  endtask
  initial begin
    logic [7:0] r;
    logic z, c;
    int lat;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", b1.in_ready, 1'b1);
    check("rst_out_valid", b1.out_valid, 1'b0);
    check("rst_ro", b1.ro, 8'h00);
    check("rst_zero", b1.zero, 1'b0);
    check("rst_chk", b1.chk_err, 1'b0);
    directed("a53", 8'h53, 8'h1B, 8'hCA, 1'b0, 1'b0);
    directed("a01", 8'h01, 8'h1B, 8'h01, 1'b0, 1'b0);
    directed("a02", 8'h02, 8'h1B, 8'h8D, 1'b0, 1'b0);
    directed("a00", 8'h00, 8'h1B, 8'h00, 1'b1, 1'b0);
    directed("g00", 8'h02, 8'h00, 8'h00, 1'b0, CE);
    xact(1'b0, 8'h53, 8'h1B, 1'b0, r, z, c, lat);
    check("bp_first", r, 8'hCA);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'(i + 7), 8'h1B);
      @(posedge clk); #1;
      check("bp_valid", b1.out_valid, 1'b1);
      check("bp_ro", b1.ro, 8'hCA);
      check("bp_in_ready", b1.in_ready, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    set_ready(1'b0, 1'b1);
    @(posedge clk); #1;
    set_ready(1'b0, 1'b0);
    check("bp_rel_ready", b1.in_ready, 1'b1);
    check("bp_rel_valid", b1.out_valid, 1'b0);
    @(posedge clk); #1;
    check("bp_idle", b1.in_ready, 1'b1);
    drive(1'b0, 1'b1, 8'h53, 8'h1B);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", b1.in_ready, 1'b1);
    check("mid_rst_valid", b1.out_valid, 1'b0);
    check("mid_rst_ro", b1.ro, 8'h00);
    directed("post_rst", 8'h53, 8'h1B, 8'hCA, 1'b0, 1'b0);
    for (int a = 1; a < 256; a++) begin
      xact(1'b1, 8'(a), 8'h1B, 1'b1, r, z, c, lat);
      check($sformatf("inv8_%02h", a), gmul(r, 8'(a), 8'h1B), 8'h01);
      check($sformatf("lat8_%02h", a), lat, NM);
    end
    xact(1'b1, 8'h00, 8'h1B, 1'b1, r, z, c, lat);
    check("b8_zero_ro", r, 8'h00);
    check("b8_zero_flag", z, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gf_inverter.md
Name: gf_inverter

Overview:
- Sequential GF(2^8) multiplicative inverter. It computes a^-1 = a^254 with a square-and-multiply chain on a bit-serial MSB-first multiplier.
- It performs the inverse operation of the 8-bit systolic multiplier array and uses the same operand conventions:
  - operands are [8:1], with bit 8 the x^7 coefficient;
  - the field polynomial is x^8 + g[8:1];
  - multiplier bits are consumed MSB first.
- It sits beside the multiplier array in the finite-field datapath and is used for division (a/b = a*b^-1).
- Valid/ready handshakes on both input and output.

Parameters:
- MUL_BITS, 1: multiplier bits processed per clock (legal 1, 2, 4, 8). Cycles per multiply C = 8/MUL_BITS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept operand
- ai  input  [8:1]  element to invert
- gi  input  [8:1]  low 8 coefficients of field polynomial (x^8 implicit)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- ro  output  [8:1]  ai^254 (inverse when ai != 0 and gi is irreducible)
- zero  output  1  ai was 0; ro = 0
- chk_err  output  1  self-check failure (see Optional Feature)

Behaviour:
- Interface conventions: one clock domain (clk); reset rst is synchronous, active-high.
- Reset values:
  - in_ready = 1; out_valid = 0; ro = 0; zero = 0; chk_err = 0;
  - FSM = IDLE; all internal registers cleared.
- Reset mid-operation: the result is discarded; in_ready = 1 on the cycle after the reset edge.
- FSM states IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch A = ai and G = gi, set R = ai, set iteration counter k = 0, go to SQR.
- SQR: compute R = R*R over C cycles.
  - If k < 6, go to MUL.
  - If k == 6, go to DONE (result = R).
- MUL: compute R = R*A over C cycles, then k = k+1 and go to SQR.
- Exponent chain: 1 → 3 → 7 → 15 → 31 → 63 → 127 (six SQR+MUL pairs), then a final SQR → 254. Total 13 multiplies.
- Multiplier step, per multiplier bit b from MSB to LSB:
  - P = xtime(P) ^ (b ? X : 0), with P initially 0;
  - xtime(P) = {P[7:1],0} ^ (P[8] ? G : 0).
  - MUL_BITS steps are chained combinationally within one clock.
- Latency:
  - out_valid rises after exactly 13*C rising edges following the accepting edge (104 for MUL_BITS=1, 13 for MUL_BITS=8).
  - With CHECK the latency is 14*C.
- DONE:
  - out_valid = 1; ro, zero and chk_err are held stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE; in_ready returns high on the next cycle. There is no overlap of output handshake and new acceptance.
- in_ready = 0 in SQR, MUL and DONE; in_valid is ignored there.
- zero = (A == 0); ro is then 0 naturally from the chain. No special path.
- G is latched at accept; changes to gi during computation have no effect.
- Non-irreducible G: the result is computed mechanically; no error is flagged unless CHECK is enabled.

Optional Feature:
- Macro: GF_INV_CHECK_EN.
- Defined:
  - after the final SQR, one extra state CHK computes A*R over C cycles;
  - chk_err = 1 if the product != 8'h01 and A != 0, else 0;
  - latency becomes 14*C; ro remains the pre-check R.
- Undefined:
  - no CHK state; chk_err is tied to 0;
  - latency is 13*C.

Test Plan:
1. MUL_BITS=1, gi=8'h1B, ai=8'h53 → after 104 cycles out_valid=1, ro=8'hCA, zero=0, chk_err=0.
2. gi=8'h1B, ai=8'h01 → ro=8'h01. ai=8'h02 → ro=8'h8D. ai=8'h00 → ro=8'h00, zero=1, chk_err=0 (also with GF_INV_CHECK_EN).
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid → ro/out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready → one transfer, in_ready=1 next cycle.
4. Assert rst at cycle 50 of a computation → next cycle in_ready=1, out_valid=0, ro=0. A fresh ai=8'h53 then yields 8'hCA.
5. MUL_BITS=8, gi=8'h1B, exhaustive ai = 1..255 → ro*ai == 1 (checked by reference model), latency 13 cycles each.
6. GF_INV_CHECK_EN defined, gi=8'h00, ai=8'h02 → ro=8'h00, chk_err=1, latency 14*C.
